ecall_service_unit: RTL
=======================

Name: ecall_service_unit

Overview:
- Multi-cycle service engine for ECALL/EBREAK in the single-cycle RISC-V core.
- Sits between the decoder and the PC/regfile write port, and the board I/O (switches, confirm button, 7-seg/LED display).
- Stalls the core while an environment call waits on the user.
- Supports parametrised widths, several ops, auto-continue print timing, EXIT halt and EBREAK breakpoint resume.

Parameters:
DATA_W, 32, register/data width
EOP_W, 12, width of ecall op code field taken from a7
SW_W, 16, switch input width
HOLD_CYCLES, 0, print auto-continue delay in cycles; 0 = wait for confirm only
CNT_W, 32, hold counter width; must hold HOLD_CYCLES

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ecall_req  in  1  current instruction is ECALL (level, from decoder)
ebreak_req  in  1  current instruction is EBREAK (level)
eop  in  EOP_W  service code (a7[EOP_W-1:0])
arg  in  DATA_W  argument (a0)
sw_in  in  SW_W  switch value
confirm  in  1  debounced confirm button (level)
stall  out  1  hold PC / suppress core register writes
reg_wen  out  1  write a0 with reg_wdata this cycle
reg_wdata  out  DATA_W  value read from switches
disp_data  out  DATA_W  value shown on display
disp_hex  out  1  1 = show disp_data as hex, 0 = signed decimal
disp_valid  out  1  display holds a printed value
halted  out  1  EXIT executed
in_break  out  1  parked at EBREAK
illegal_op  out  1  one-cycle pulse on unknown service code

Behaviour:
- Reset: state IDLE. All outputs are 0, including disp_data, the hold counter and the confirm edge register.
- Reset mid-operation aborts the service, with no write-back.
- Confirm edge:
  - cfm_prev <= confirm every cycle; cfm_rise = confirm & ~cfm_prev.
  - A button already held on entry to a wait state must be released and pressed again.
- Ops (package constants):
  - PRINT_INT=1: display, decimal.
  - PRINT_HEX=34: display, hex.
  - READ_INT=5: sign-extend sw_in to DATA_W.
  - READ_CHAR=12: zero-extend sw_in[7:0].
  - EXIT=10: halt.
- stall is combinational:
  - In IDLE: stall = ebreak_req | (ecall_req & known(eop)).
  - In WAIT_PRINT, WAIT_READ, BREAK, HALT: stall = 1.
  - In DONE: stall = 0.
- IDLE transitions:
  - ebreak_req has priority -> BREAK.
  - ecall_req with a print op -> WAIT_PRINT. Latch disp_data <= arg, disp_hex per op, disp_valid <= 1, load the hold counter.
  - ecall_req with a read op -> WAIT_READ. Latch the op.
  - ecall_req with EXIT -> HALT.
  - ecall_req with an unknown eop: no stall, illegal_op = 1 in the next cycle, stay in IDLE (treated as NOP).
- WAIT_PRINT:
  - Leaves on cfm_rise, or on counter reaching 0 when HOLD_CYCLES != 0 (counter decrements each cycle) -> DONE.
  - disp_data persists until the next print or reset.
- WAIT_READ:
  - On cfm_rise, sample sw_in that cycle into reg_wdata (extended per op) -> DONE.
- DONE: exactly one cycle.
  - stall = 0, so the PC advances.
  - reg_wen = 1 only if the service was a read.
  - ecall_req is ignored in DONE (same instruction); next state IDLE.
- BREAK: in_break = 1. On cfm_rise -> DONE with reg_wen = 0.
- HALT: halted = 1 and stall = 1 until rst. All requests are ignored.
- Latency:
  - Print with HOLD_CYCLES = N: N+1 stalled cycles from the request cycle, then the DONE cycle.
  - Read: stalled until the cycle after cfm_rise.

Decomposition:
- Shared package/header: EOP_* codes, FSM state encoding (IDLE, WAIT_PRINT, WAIT_READ, BREAK, HALT, DONE), and the width/extension helper for reads.
- Sub-module: edge_detect (one-bit registered rising-edge detector, synchronous reset).
- FSM, counter and datapath stay in the top module.

Test Plan:
- READ_INT with sw_in=16'hFFFE; confirm pulse after 10 cycles -> stall high 11 cycles, then one DONE cycle with reg_wen=1, reg_wdata=32'hFFFF_FFFE.
- PRINT_HEX with arg=32'hDEAD_BEEF, HOLD_CYCLES=4, confirm never pressed -> disp_data=DEADBEEF, disp_hex=1, stall for 5 cycles, DONE, reg_wen never 1.
- READ_CHAR with confirm already held high on entry -> no completion until released and re-pressed. Then reg_wdata = {24'h0, sw_in[7:0]}.
- eop=7 (unknown) -> stall 0, illegal_op pulse for 1 cycle, state stays IDLE.
- EXIT -> halted=1 and stall=1 permanently. Further ecall_req/confirm have no effect; rst clears halted and stall to 0.
- EBREAK then confirm; rst asserted mid-WAIT_READ -> in_break drops after confirm with no reg_wen. Reset returns to IDLE with all outputs 0 and no write-back.

Source files
------------

// File: rtl/ecall_service_unit_pkg.sv
// Shared definitions for the ECALL/EBREAK service engine: service codes,
// FSM state encoding and the switch-read extension helper.
package ecall_service_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_PRINT = 3'd1,
        ST_WAIT_READ  = 3'd2,
        ST_BREAK      = 3'd3,
        ST_HALT       = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    // Service codes carried in a7; compared after zero-extension to 32 bits.
    localparam logic [31:0] EOP_PRINT_INT = 32'd1;
    localparam logic [31:0] EOP_PRINT_HEX = 32'd34;
    localparam logic [31:0] EOP_READ_INT  = 32'd5;
    localparam logic [31:0] EOP_READ_CHAR = 32'd12;
    localparam logic [31:0] EOP_EXIT      = 32'd10;

    // Widest register the read helper can produce; the top truncates to DATA_W.
    localparam int EXT_W = 64;

    function automatic logic is_print(input logic [31:0] op);
        return (op == EOP_PRINT_INT) || (op == EOP_PRINT_HEX);
    endfunction

    function automatic logic is_read(input logic [31:0] op);
        return (op == EOP_READ_INT) || (op == EOP_READ_CHAR);
    endfunction

    function automatic logic is_exit(input logic [31:0] op);
        return op == EOP_EXIT;
    endfunction

    function automatic logic is_known(input logic [31:0] op);
        return is_print(op) || is_read(op) || is_exit(op);
    endfunction

    // READ_CHAR zero-extends the low byte; READ_INT sign-extends the
    // sw_w-bit switch value.
    function automatic logic [EXT_W-1:0] extend_read(input logic [EXT_W-1:0] sw,
                                                     input int sw_w,
                                                     input logic is_char);
        logic [EXT_W-1:0] upper_mask;
        logic             sign;
        logic [EXT_W-1:0] res;
        upper_mask = {EXT_W{1'b1}} << sw_w;
        sign       = |(sw & ({{(EXT_W-1){1'b0}}, 1'b1} << (sw_w - 1)));
        if (is_char)
            res = {{(EXT_W-8){1'b0}}, sw[7:0]};
        else if (sign)
            res = sw | upper_mask;
        else
            res = sw & ~upper_mask;
        return res;
    endfunction

endpackage

// File: rtl/ecall_service_unit_edge_detect.sv
// One-bit registered rising-edge detector. A level already high when the
// detector starts watching gives no edge until it drops and rises again.
module ecall_service_unit_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic prev_q;

    // Remember last cycle's level.
    always_ff @(posedge clk) begin
        if (rst)
            prev_q <= 1'b0;
        else
            prev_q <= d;
    end

    assign rise = d & ~prev_q;

endmodule

// File: rtl/ecall_service_unit.sv
// ECALL/EBREAK service engine: stalls the single-cycle core while a print,
// read, breakpoint or exit waits on the board I/O, then releases it for one
// DONE cycle (with a0 write-back for reads).
module ecall_service_unit #(
    parameter int DATA_W      = 32,
    parameter int EOP_W       = 12,
    parameter int SW_W        = 16,
    parameter int HOLD_CYCLES = 0,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ecall_req,
    input  logic              ebreak_req,
    input  logic [EOP_W-1:0]  eop,
    input  logic [DATA_W-1:0] arg,
    input  logic [SW_W-1:0]   sw_in,
    input  logic              confirm,
    output logic              stall,
    output logic              reg_wen,
    output logic [DATA_W-1:0] reg_wdata,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_hex,
    output logic              disp_valid,
    output logic              halted,
    output logic              in_break,
    output logic              illegal_op
);

    import ecall_service_unit_pkg::*;

    // Counter is loaded so that WAIT_PRINT lasts HOLD_CYCLES cycles; with the
    // request cycle that gives HOLD_CYCLES+1 stalled cycles.
    localparam logic [CNT_W-1:0] CNT_LOAD = (HOLD_CYCLES == 0) ? '0 : CNT_W'(HOLD_CYCLES - 1);

    state_t            state_q, state_n;
    logic [31:0]       eop_w;
    logic [31:0]       op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              cfm_rise;
    logic              hold_expired;

    assign eop_w        = 32'(eop);
    assign hold_expired = (HOLD_CYCLES != 0) && (cnt_q == '0);

    ecall_service_unit_edge_detect u_cfm_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (confirm),
        .rise (cfm_rise)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_n;
    end

    // Next-state logic: ebreak beats ecall; unknown codes stay in IDLE.
    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ebreak_req)
                    state_n = ST_BREAK;
                else if (ecall_req) begin
                    if (is_print(eop_w))
                        state_n = ST_WAIT_PRINT;
                    else if (is_read(eop_w))
                        state_n = ST_WAIT_READ;
                    else if (is_exit(eop_w))
                        state_n = ST_HALT;
                end
            end
            ST_WAIT_PRINT: if (cfm_rise || hold_expired) state_n = ST_DONE;
            ST_WAIT_READ:  if (cfm_rise) state_n = ST_DONE;
            ST_BREAK:      if (cfm_rise) state_n = ST_DONE;
            ST_HALT:       state_n = ST_HALT;
            ST_DONE:       state_n = ST_IDLE;
            default:       state_n = ST_IDLE;
        endcase
    end

    // Outputs decoded from the current state; only IDLE looks at the request.
    always_comb begin
        stall    = 1'b1;
        reg_wen  = 1'b0;
        halted   = 1'b0;
        in_break = 1'b0;
        case (state_q)
            ST_IDLE:  stall = ebreak_req | (ecall_req & is_known(eop_w));
            ST_DONE: begin
                stall   = 1'b0;
                reg_wen = is_read(op_q);
            end
            ST_HALT:  halted = 1'b1;
            ST_BREAK: in_break = 1'b1;
            default:  stall = 1'b1;
        endcase
    end

    // Service datapath: latched op, display registers, hold counter,
    // switch sample and the illegal-code pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= '0;
            cnt_q      <= '0;
            disp_data  <= '0;
            disp_hex   <= 1'b0;
            disp_valid <= 1'b0;
            reg_wdata  <= '0;
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ebreak_req)
                        op_q <= '0;
                    else if (ecall_req) begin
                        op_q <= eop_w;
                        if (is_print(eop_w)) begin
                            disp_data  <= arg;
                            disp_hex   <= (eop_w == EOP_PRINT_HEX);
                            disp_valid <= 1'b1;
                            cnt_q      <= CNT_LOAD;
                        end
                        if (!is_known(eop_w))
                            illegal_op <= 1'b1;
                    end
                end
                ST_WAIT_PRINT: begin
                    if (cnt_q != '0)
                        cnt_q <= cnt_q - 1'b1;
                end
                ST_WAIT_READ: begin
                    if (cfm_rise)
                        reg_wdata <= DATA_W'(extend_read(EXT_W'(sw_in), SW_W,
                                                         op_q == EOP_READ_CHAR));
                end
                default: ;
            endcase
        end
    end

endmodule
